// File: rtl/w5300_pkg.sv
// Shared definitions for the W5300 transmit path: framer state encoding,
// default buffer widths and the tx_len width rule.
package w5300_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 12;

  typedef enum logic [2:0] {
    S_INIT,
    S_FILL,
    S_REQ,
    S_WAIT_ACK,
    S_WAIT_DONE
  } framer_state_t;

  // One extra bit so a packet that fills the whole buffer is still representable.
  function automatic int tx_len_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/udp_tx_framer_if.sv
// Sample stream, TX buffer write port and W5300 driver handshake of the framer.
// The master view belongs to udp_tx_framer, the slave view to its surroundings.
interface udp_tx_framer_if #(
  parameter int ADDR_WIDTH = w5300_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = w5300_pkg::DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;

  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_wren;

  logic                                            tx_req;
  logic [w5300_pkg::tx_len_width(ADDR_WIDTH)-1:0]  tx_len;
  logic                                            busy_n;
  logic                                            ack_timeout;

  modport master (
    input  in_data, in_valid, flush, busy_n,
    output in_ready, buf_addr, buf_data, buf_wren, tx_req, tx_len, ack_timeout
  );

  modport slave (
    output in_data, in_valid, flush, busy_n,
    input  in_ready, buf_addr, buf_data, buf_wren, tx_req, tx_len, ack_timeout
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; hit is high while the count
// sits at LIMIT.
module sat_counter #(
  parameter int LIMIT = 255,
  parameter int WIDTH = $clog2(LIMIT) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt;

  // NOTE: flops take <= so every register samples pre-edge values whatever the block order.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIM) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign hit = (cnt == LIM);

endmodule

// File: rtl/udp_tx_framer.sv
// Fills the UDP TX buffer from a 12-bit sample stream and hands each packet to
// the W5300 driver with a tx_req pulse, retrying if the driver never goes busy.
module udp_tx_framer
  import w5300_pkg::*;
#(
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int PKT_WORDS          = 512,
  parameter int IDLE_FLUSH_CYCLES  = 10000,
  parameter int ACK_TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  udp_tx_framer_if.master bus
);

  localparam int                   CNT_WIDTH = tx_len_width(ADDR_WIDTH);
  localparam logic [CNT_WIDTH-1:0] PKT_FULL  = CNT_WIDTH'(PKT_WORDS);

  framer_state_t         state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  len_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  wren_q;
  logic                  req_q;
  logic                  timeout_q;

  logic accept;
  logic full_next;
  logic flush_go;
  logic idle_hit;
  logic ack_hit;

  // ready_q is only ever high in S_FILL, so accept needs no state term.
  assign accept    = ready_q && bus.in_valid;
  assign full_next = accept && (count + CNT_WIDTH'(1) == PKT_FULL);
  assign flush_go  = (bus.flush || idle_hit) && (count != '0);

  sat_counter #(.LIMIT(IDLE_FLUSH_CYCLES)) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || state != S_FILL),
    .inc   (state == S_FILL && count != '0 && !accept),
    .hit   (idle_hit)
  );

  sat_counter #(.LIMIT(ACK_TIMEOUT_CYCLES)) u_ack_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == S_REQ),
    .inc   (state == S_WAIT_ACK),
    .hit   (ack_hit)
  );

  // busy_n is registered once, which sets the two-cycle busy_n-to-in_ready turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_INIT;
      wr_ptr    <= '0;
      count     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      wren_q    <= 1'b0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      busy_q <= bus.busy_n;
      wren_q <= 1'b0;
      req_q  <= 1'b0;

      case (state)
        S_INIT: begin
          if (busy_q) begin
            state   <= S_FILL;
            ready_q <= 1'b1;
          end
        end

        S_FILL: begin
          if (accept) begin
            addr_q <= wr_ptr;
            data_q <= bus.in_data;
            wren_q <= 1'b1;
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            count  <= count + CNT_WIDTH'(1);
          end
          if (full_next || flush_go) begin
            state   <= S_REQ;
            ready_q <= 1'b0;
          end
        end

        S_REQ: begin
          req_q <= 1'b1;
          len_q <= count;
          state <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (!busy_q) begin
            state <= S_WAIT_DONE;
          end else if (ack_hit) begin
            timeout_q <= 1'b1;
            state     <= S_REQ;
          end
        end

        S_WAIT_DONE: begin
          if (busy_q) begin
            wr_ptr  <= '0;
            count   <= '0;
            state   <= S_FILL;
            ready_q <= 1'b1;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.buf_addr    = addr_q;
  assign bus.buf_data    = data_q;
  assign bus.buf_wren    = wren_q;
  assign bus.tx_req      = req_q;
  assign bus.tx_len      = len_q;
  assign bus.ack_timeout = timeout_q;

endmodule
